// File: rtl/cache_pkg.sv
// Shared types and address helpers for the write-through data cache controller.
package cache_pkg;

  typedef enum logic [2:0] {
    FLUSH,
    IDLE,
    LOOKUP,
    REFILL,
    WMEM
  } state_t;

  function automatic int tag_width(input int data_width, input int address_width);
    return data_width - address_width - 2;
  endfunction

  // Helpers work on a 64-bit view; callers size-cast the result to their field width.
  function automatic logic [63:0] addr_index(input logic [63:0] addr, input int address_width);
    return (addr >> 2) & ((64'd1 << address_width) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int address_width);
    return addr >> (address_width + 2);
  endfunction

endpackage

// File: rtl/cache_line_ram.sv
// Tag/valid/data arrays for a direct-mapped, one-word-per-line cache.
module cache_line_ram #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int TAG_WIDTH     = 26
) (
  input  logic                     iCLK,
  input  logic [ADDRESS_WIDTH-1:0] iRdIdx,
  output logic                     oRdValid,
  output logic [TAG_WIDTH-1:0]     oRdTag,
  output logic [DATA_WIDTH-1:0]    oRdData,
  input  logic [ADDRESS_WIDTH-1:0] iWrIdx,
  input  logic                     iClrValid,
  input  logic                     iWrLine,
  input  logic                     iWrData,
  input  logic [TAG_WIDTH-1:0]     iWrTag,
  input  logic [DATA_WIDTH-1:0]    iWrWord
);

  localparam int unsigned LINES = 2 ** ADDRESS_WIDTH;

  logic [LINES-1:0]      valid;
  logic [TAG_WIDTH-1:0]  tags  [LINES];
  logic [DATA_WIDTH-1:0] words [LINES];

  always_ff @(posedge iCLK) begin
    if (iClrValid) begin
      valid[iWrIdx] <= 1'b0;
    end else if (iWrLine) begin
      valid[iWrIdx] <= 1'b1;
      tags[iWrIdx]  <= iWrTag;
      words[iWrIdx] <= iWrWord;
    end else if (iWrData) begin
      words[iWrIdx] <= iWrWord;
    end
  end

  always_ff @(posedge iCLK) begin
    oRdValid <= valid[iRdIdx];
    oRdTag   <= tags[iRdIdx];
    oRdData  <= words[iRdIdx];
  end

endmodule

// File: rtl/cache_refill_ctrl.sv
// Request/refill controller: tag compare, read-miss refill, write-through stores,
// and the valid-clear walk after reset or flush.
module cache_refill_ctrl #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int TAG_WIDTH     = cache_pkg::tag_width(DATA_WIDTH, ADDRESS_WIDTH)
) (
  input  logic                  iCLK,
  input  logic                  iRST_N,
  input  logic                  iReq,
  input  logic                  iWe,
  input  logic [DATA_WIDTH-1:0] iAddr,
  input  logic [DATA_WIDTH-1:0] iWData,
  input  logic                  iFlush,
  output logic                  oReady,
  output logic                  oAck,
  output logic [DATA_WIDTH-1:0] oRData,
  output logic                  oMemReq,
  output logic                  oMemWe,
  output logic [DATA_WIDTH-1:0] oMemAddr,
  output logic [DATA_WIDTH-1:0] oMemWData,
  input  logic                  iMemAck,
  input  logic [DATA_WIDTH-1:0] iMemRData
);
  import cache_pkg::*;

  state_t state, state_n;

  logic [ADDRESS_WIDTH-1:0] flush_cnt;
  logic                     req_we;
  logic [ADDRESS_WIDTH-1:0] req_idx;
  logic [TAG_WIDTH-1:0]     req_tag;
  logic [DATA_WIDTH-1:0]    req_wdata;

  logic [ADDRESS_WIDTH-1:0] in_idx;
  logic [TAG_WIDTH-1:0]     in_tag;
  logic                     accept, flush_go, mem_done, hit;

  logic                     rd_valid;
  logic [TAG_WIDTH-1:0]     rd_tag;
  logic [DATA_WIDTH-1:0]    rd_data;

  logic                     ready_d, ack_d, mreq_d, mwe_d;
  logic [DATA_WIDTH-1:0]    rdata_d, maddr_d, mwdata_d;
  logic                     clr_en, line_we, data_we;

  assign in_idx   = ADDRESS_WIDTH'(addr_index(64'(iAddr), ADDRESS_WIDTH));
  assign in_tag   = TAG_WIDTH'(addr_tag(64'(iAddr), ADDRESS_WIDTH));
  assign flush_go = (state == IDLE) && oReady && iFlush;
  assign accept   = (state == IDLE) && oReady && iReq && !iFlush;
  assign mem_done = oMemReq && iMemAck;
  assign hit      = rd_valid && (rd_tag == req_tag);

  // Writes are gated by reset so an abandoned refill cannot land in the arrays.
  cache_line_ram #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .TAG_WIDTH     (TAG_WIDTH)
  ) u_ram (
    .iCLK      (iCLK),
    .iRdIdx    (in_idx),
    .oRdValid  (rd_valid),
    .oRdTag    (rd_tag),
    .oRdData   (rd_data),
    .iWrIdx    ((state == FLUSH) ? flush_cnt : req_idx),
    .iClrValid (clr_en && iRST_N),
    .iWrLine   (line_we && iRST_N),
    .iWrData   (data_we && iRST_N),
    .iWrTag    (req_tag),
    .iWrWord   ((state == REFILL) ? iMemRData : req_wdata)
  );

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state     <= FLUSH;
      flush_cnt <= '0;
      req_we    <= 1'b0;
      req_idx   <= '0;
      req_tag   <= '0;
      req_wdata <= '0;
      oReady    <= 1'b0;
      oAck      <= 1'b0;
      oRData    <= '0;
      oMemReq   <= 1'b0;
      oMemWe    <= 1'b0;
      oMemAddr  <= '0;
      oMemWData <= '0;
    end else begin
      state <= state_n;
      if (state == FLUSH) flush_cnt <= flush_cnt + 1'b1;
      else if (flush_go)  flush_cnt <= '0;
      if (accept) begin
        req_we    <= iWe;
        req_idx   <= in_idx;
        req_tag   <= in_tag;
        req_wdata <= iWData;
      end
      oReady    <= ready_d;
      oAck      <= ack_d;
      oRData    <= rdata_d;
      oMemReq   <= mreq_d;
      oMemWe    <= mwe_d;
      oMemAddr  <= maddr_d;
      oMemWData <= mwdata_d;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      FLUSH:   if (flush_cnt == '1) state_n = IDLE;
      IDLE:    if (flush_go) state_n = FLUSH;
               else if (accept) state_n = LOOKUP;
      LOOKUP:  if (req_we) state_n = WMEM;
               else if (hit) state_n = IDLE;
               else state_n = REFILL;
      REFILL,
      WMEM:    if (mem_done) state_n = IDLE;
      default: state_n = FLUSH;
    endcase
  end

  always_comb begin
    ack_d    = 1'b0;
    rdata_d  = oRData;
    mreq_d   = oMemReq;
    mwe_d    = oMemWe;
    maddr_d  = oMemAddr;
    mwdata_d = oMemWData;
    clr_en   = 1'b0;
    line_we  = 1'b0;
    data_we  = 1'b0;
    case (state)
      FLUSH: clr_en = 1'b1;
      LOOKUP: begin
        if (req_we) begin
          data_we  = hit;
          mreq_d   = 1'b1;
          mwe_d    = 1'b1;
          maddr_d  = {req_tag, req_idx, 2'b00};
          mwdata_d = req_wdata;
        end else if (hit) begin
          ack_d   = 1'b1;
          rdata_d = rd_data;
        end else begin
          mreq_d  = 1'b1;
          mwe_d   = 1'b0;
          maddr_d = {req_tag, req_idx, 2'b00};
        end
      end
      REFILL: if (mem_done) begin
        line_we = 1'b1;
        rdata_d = iMemRData;
        ack_d   = 1'b1;
        mreq_d  = 1'b0;
      end
      WMEM: if (mem_done) begin
        ack_d  = 1'b1;
        mreq_d = 1'b0;
      end
      default: ;
    endcase
    // Ready is held off during the ack cycle so it rises one cycle after oAck.
    ready_d = (state_n == IDLE) && !ack_d;
  end

endmodule
